// File: rtl/program_fetch_sequencer.sv
// Fetch/issue sequencer for the 4-bit computer: owns the PC, reads the
// combinational program ROM, and hands each word to execute over valid/ready.
module program_fetch_sequencer #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] ISSUE  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_halted;
  logic              w_is_halt;
  logic              w_handshake;

  assign w_is_halt   = (rom_data[DATA_W-1 -: 4] == HALT_OP);
  assign w_handshake = (r_state == ISSUE) && instr_ready;

  // Outputs derive directly from state so an async reset clears them at once.
  assign rom_addr    = r_pc;
  assign pc          = r_pc;
  assign instr_valid = (r_state == ISSUE);
  assign opcode      = r_ir[DATA_W-1 -: 4];
  assign operand     = r_ir[3:0];
  assign halted      = r_halted;
  assign busy        = (r_state == FETCH) || (r_state == ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) r_state <= FETCH;
        end
        FETCH: begin
          r_ir <= rom_data;
          // A HALT word parks the PC on its own address and is never issued.
          if (w_is_halt) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else begin
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_handshake) begin
            if (jump_en) r_pc <= jump_addr;
            r_state <= FETCH;
          end
        end
        HALTED: begin
          if (start) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
            r_state  <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
